// File: rtl/ce_divider.sv
// Multi-channel clock-enable generator: per-channel integer divider or fractional NCO,
// each with a registered one-cycle strobe and a 50 % duty square output.
module ce_divider #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8,
    parameter int FRAC_W = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     sync,
    input  logic [NUM_CH-1:0]        mode,
    input  logic [NUM_CH*DIV_W-1:0]  div,
    input  logic [NUM_CH*FRAC_W-1:0] inc,
    output logic [NUM_CH-1:0]        ce,
    output logic [NUM_CH-1:0]        sq
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            logic [DIV_W-1:0]  cnt_q, cnt_d;
            logic [FRAC_W-1:0] acc_q, acc_d;
            logic              ce_q, ce_d;
            logic              sq_q, sq_d;
            logic [DIV_W-1:0]  div_i;
            logic [DIV_W-1:0]  last_i;
            logic [FRAC_W-1:0] inc_i;
            logic [FRAC_W:0]   sum_i;

            assign div_i = div[gi*DIV_W +: DIV_W];
            assign inc_i = inc[gi*FRAC_W +: FRAC_W];

            always_comb begin
                // div = 0 behaves as a period of 1, so the terminal count is 0 as well
                last_i = (div_i == '0) ? '0 : div_i - DIV_W'(1);
                sum_i  = {1'b0, acc_q} + {1'b0, inc_i};
                cnt_d  = cnt_q;
                acc_d  = acc_q;
                ce_d   = 1'b0;
                sq_d   = sq_q;
                if (sync) begin
                    cnt_d = '0;
                    acc_d = '0;
                    sq_d  = 1'b0;
                end else if (en) begin
                    if (mode[gi]) begin
                        acc_d = sum_i[FRAC_W-1:0];
                        ce_d  = sum_i[FRAC_W];
                    end else if (cnt_q >= last_i) begin
                        // >= rather than == so a shrunk divisor wraps on the next edge
                        cnt_d = '0;
                        ce_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                    sq_d = sq_q ^ ce_d;
                end
            end

            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                    acc_q <= '0;
                    ce_q  <= 1'b0;
                    sq_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    acc_q <= acc_d;
                    ce_q  <= ce_d;
                    sq_q  <= sq_d;
                end
            end

            assign ce[gi] = ce_q;
            assign sq[gi] = sq_q;
        end
    endgenerate

endmodule

// File: tb/tb_ce_divider.sv
// Scoreboard bench for ce_divider: stimulus pushes hand-computed ce/sq per edge,
// a monitor pops and compares one entry after each rising edge.
module tb_ce_divider;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;
    localparam int FRAC_W = 16;

    logic                     clk_sys = 1'b0;
    logic                     reset;
    logic                     en;
    logic                     sync;
    logic [NUM_CH-1:0]        mode;
    logic [NUM_CH*DIV_W-1:0]  div;
    logic [NUM_CH*FRAC_W-1:0] inc;
    logic [NUM_CH-1:0]        ce;
    logic [NUM_CH-1:0]        sq;

    ce_divider #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .FRAC_W(FRAC_W)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .en      (en),
        .sync    (sync),
        .mode    (mode),
        .div     (div),
        .inc     (inc),
        .ce      (ce),
        .sq      (sq)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0] ce;
        logic [1:0] sq;
        string      tag;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_sq = 2'b00;

    // Monitor: one expected entry per rising edge, pushed before that edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (ce !== e.ce || sq !== e.sq) begin
                    errors++;
                    $display("FAIL %s: ce=%b sq=%b required ce=%b sq=%b", e.tag, ce, sq, e.ce, e.sq);
                end else begin
                    $display("ok   %s: ce=%b sq=%b", e.tag, ce, sq);
                end
            end
        end
    end

    task automatic push_and_step(input logic [1:0] c, input string tag);
        exp_t e;
        e.ce = c;
        e.sq = exp_sq;
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk_sys);
        #2;
    endtask

    // Bit k of p0/p1 is the expected ce of ch0/ch1 after the (k+1)-th edge of the segment
    task automatic run_vec(input int n, input logic [63:0] p0, input logic [63:0] p1, input string tag);
        logic [1:0] c;
        for (int k = 0; k < n; k++) begin
            c = {p1[k], p0[k]};
            exp_sq = exp_sq ^ c;
            push_and_step(c, $sformatf("%s[%0d]", tag, k + 1));
        end
    endtask

    task automatic sync_pulse(input logic en_val, input string tag);
        sync = 1'b1;
        en = en_val;
        exp_sq = 2'b00;
        push_and_step(2'b00, tag);
        sync = 1'b0;
        en = 1'b1;
    endtask

    task automatic direct_check(input string tag, input logic [1:0] req_ce, input logic [1:0] req_sq);
        checks++;
        if (ce !== req_ce || sq !== req_sq) begin
            errors++;
            $display("FAIL %s: ce=%b sq=%b required ce=%b sq=%b", tag, ce, sq, req_ce, req_sq);
        end else begin
            $display("ok   %s: ce=%b sq=%b", tag, ce, sq);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        sync  = 1'b0;
        mode  = 2'b00;
        div   = {8'd1, 8'd4};
        inc   = '0;
        repeat (3) @(posedge clk_sys);
        #2;
        direct_check("reset_state", 2'b00, 2'b00);

        // Integer: ch0 div=4, ch1 div=1
        en = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        run_vec(12, 64'b1000_1000_1000, 64'hFFF, "int_div4_div1");

        // sync then ch1 div=0 (period 1)
        div = {8'd0, 8'd4};
        sync_pulse(1'b1, "sync_pulse");
        run_vec(8, 64'b1000_1000, 64'hFF, "after_sync");

        // en low for 5 cycles mid-count: ch0 holds cnt=2
        run_vec(2, 64'b00, 64'b11, "pre_hold");
        en = 1'b0;
        run_vec(5, 64'b0, 64'b0, "en_low");
        en = 1'b1;
        run_vec(6, 64'b100010, 64'h3F, "resume");

        // sync wins over en=0 in the same cycle
        sync_pulse(1'b0, "sync_en_low");

        // Divisor shrink on ch0; ch1 fractional 0x4000 from acc=0
        div  = {8'd0, 8'd10};
        mode = 2'b10;
        inc  = {16'h4000, 16'h0000};
        run_vec(6, 64'b0, 64'b001000, "div10_to_cnt6");
        div = {8'd0, 8'd3};
        run_vec(7, 64'b1001001, 64'b0100010, "div_shrink3");

        // Fractional 0xC000 on ch1, 0 on ch0
        mode = 2'b11;
        inc  = {16'hC000, 16'h0000};
        sync_pulse(1'b1, "sync_frac");
        run_vec(8, 64'b0, 64'b11101110, "frac_c000");

        // inc = 0 on both channels: no strobe for 1000 cycles
        inc = '0;
        for (int b = 0; b < 20; b++)
            run_vec(50, 64'b0, 64'b0, $sformatf("inc0_blk%0d", b));

        // Async reset between edges while ce = 1
        mode = 2'b00;
        div  = {8'd1, 8'd1};
        sync_pulse(1'b1, "sync_pre_reset");
        run_vec(1, 64'b1, 64'b1, "div1_pre_reset");
        reset = 1'b1;
        #1;
        direct_check("async_reset", 2'b00, 2'b00);
        exp_sq = 2'b00;
        repeat (2) @(posedge clk_sys);

        // After release: ch0 div=2, ch1 fractional 0x8000
        mode = 2'b10;
        div  = {8'd0, 8'd2};
        inc  = {16'h8000, 16'h0000};
        en   = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        run_vec(6, 64'b101010, 64'b101010, "post_reset_mix");

        @(posedge clk_sys);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d required=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
